// File: rtl/fft_feeder_pkg.sv
// fft_feeder_pkg: shared types and helpers for the FFT frame feeder.
//   state_e    - feeder FSM states (idle, issuing reads, draining output)
//   PTS_W      - width of the frame-length field (clog2(16)+1)
//   beat_t     - one output beat {re, im, sop, eop}
//   pts_legal  - true for power-of-two frame lengths in [2, max_pts]
package fft_feeder_pkg;

    localparam int unsigned PTS_W       = 5;
    localparam int unsigned BEAT_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] re;
        logic [BEAT_DATA_W-1:0] im;
        logic                   sop;
        logic                   eop;
    } beat_t;

    function automatic logic pts_legal(input logic [PTS_W-1:0] pts,
                                       input int unsigned      max_pts);
        logic [PTS_W-1:0] pm1;
        pm1 = pts - PTS_W'(1);
        return (pts >= PTS_W'(2)) && ((pts & pm1) == '0) && (32'(pts) <= max_pts);
    endfunction

endpackage

// File: rtl/fft_feeder_skid_fifo.sv
// fft_feeder_skid_fifo: 2-entry FIFO used as the feeder output buffer.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   push     - write wdata this cycle (allowed when full only together with pop)
//   wdata    - entry to write
//   pop      - drop the head entry this cycle (must not be asserted when empty)
//   rdata    - head entry; stable until popped
//   count    - occupancy, 0..2
module fft_feeder_skid_fifo #(
    parameter int unsigned Width = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: streams one frame of complex samples from a sample RAM into the sink
// port of a streaming FFT core, reading along a grid line at base + k*stride.
// Optional feature macro: FFT_FEEDER_INV_EN adds start_inverse, which swaps real/imag.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   start, start_pts             - frame request (legal N: power of two, 2..MAX_PTS)
//   start_base, start_stride     - address of sample 0 and increment between samples
//   start_inverse (optional)     - latched per frame; swaps real/imag on the output
//   busy, done, cfg_err          - status: frame active, frame finished, illegal N
//   rd_en, rd_addr               - RAM read request
//   rd_real, rd_imag             - RAM data, valid the cycle after rd_en
//   src_valid/ready/sop/eop      - FFT sink handshake and framing
//   src_real, src_imag           - sample data
//   src_error, src_fftpts        - constant 0, frame length of the current frame
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_PTS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PTS_W-1:0]  start_pts,
    input  logic [ADDR_W-1:0] start_base,
    input  logic [ADDR_W-1:0] start_stride,
`ifdef FFT_FEEDER_INV_EN
    input  logic              start_inverse,
`endif
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_real,
    input  logic [DATA_W-1:0] rd_imag,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [DATA_W-1:0] src_real,
    output logic [DATA_W-1:0] src_imag,
    output logic [1:0]        src_error,
    output logic [PTS_W-1:0]  src_fftpts
);

    if (DATA_W != BEAT_DATA_W) begin : g_data_w_check
        $error("DATA_W must equal fft_feeder_pkg::BEAT_DATA_W");
    end
    if ($clog2(MAX_PTS) + 1 != PTS_W) begin : g_pts_w_check
        $error("MAX_PTS does not match fft_feeder_pkg::PTS_W");
    end

    state_e            state_q;
    logic [PTS_W-1:0]  pts_q;
    logic [PTS_W-1:0]  idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic              rd_vld_q;   // RAM data for an issued read arrives this cycle
    logic              rd_sop_q;
    logic              rd_eop_q;
    logic              done_q;
    logic              cfg_err_q;
`ifdef FFT_FEEDER_INV_EN
    logic              inv_q;
`endif

    beat_t      ram_beat;
    beat_t      head_beat;
    beat_t      out_beat;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       xfer;
    logic       last_issue;

    // Reads in flight count against the FIFO so returning data always has a slot.
    assign rd_en      = (state_q == StRun) &&
                        (({1'b0, fifo_count} + {2'b00, rd_vld_q}) < 3'd2);
    assign last_issue = rd_en && (idx_q == pts_q - PTS_W'(1));

    always_comb begin
        ram_beat     = '0;
`ifdef FFT_FEEDER_INV_EN
        ram_beat.re  = inv_q ? rd_imag : rd_real;
        ram_beat.im  = inv_q ? rd_real : rd_imag;
`else
        ram_beat.re  = rd_real;
        ram_beat.im  = rd_imag;
`endif
        ram_beat.sop = rd_sop_q;
        ram_beat.eop = rd_eop_q;
    end

    // An empty FIFO lets arriving RAM data through in the same cycle; if that beat is
    // not taken it is written into the FIFO and presented unchanged from there.
    assign fifo_empty = (fifo_count == 2'd0);
    assign src_valid  = !fifo_empty || rd_vld_q;
    assign out_beat   = fifo_empty ? ram_beat : head_beat;
    assign xfer       = src_valid && src_ready;
    assign fifo_pop   = xfer && !fifo_empty;
    assign fifo_push  = rd_vld_q && !(fifo_empty && xfer);

    fft_feeder_skid_fifo #(
        .Width ($bits(beat_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (ram_beat),
        .pop   (fifo_pop),
        .rdata (head_beat),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pts_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            stride_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_sop_q  <= 1'b0;
            rd_eop_q  <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef FFT_FEEDER_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            rd_vld_q  <= rd_en;
            if (rd_en) begin
                rd_sop_q <= (idx_q == '0);
                rd_eop_q <= (idx_q == pts_q - PTS_W'(1));
                addr_q   <= addr_q + stride_q;
                idx_q    <= idx_q + PTS_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (pts_legal(start_pts, MAX_PTS)) begin
                            pts_q    <= start_pts;
                            addr_q   <= start_base;
                            stride_q <= start_stride;
                            idx_q    <= '0;
`ifdef FFT_FEEDER_INV_EN
                            inv_q    <= start_inverse;
`endif
                            state_q  <= StRun;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (last_issue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (xfer && out_beat.eop) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign rd_addr    = addr_q;
    // Gated so idle outputs read as zero rather than stale RAM bus contents.
    assign src_sop    = src_valid && out_beat.sop;
    assign src_eop    = src_valid && out_beat.eop;
    assign src_real   = src_valid ? out_beat.re : '0;
    assign src_imag   = src_valid ? out_beat.im : '0;
    assign src_error  = 2'b00;
    assign src_fftpts = pts_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
module tb_fft_frame_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  start_pts;
    logic [9:0]  start_base;
    logic [9:0]  start_stride;
    logic        start_inverse;
    logic        busy, done, cfg_err, rd_en;
    logic [9:0]  rd_addr;
    logic [31:0] rd_real, rd_imag;
    logic        src_valid, src_ready, src_sop, src_eop;
    logic [31:0] src_real, src_imag;
    logic [1:0]  src_error;
    logic [4:0]  src_fftpts;

    always #5 clk = ~clk;

    fft_frame_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_pts    (start_pts),
        .start_base   (start_base),
        .start_stride (start_stride),
`ifdef FFT_FEEDER_INV_EN
        .start_inverse(start_inverse),
`endif
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_real      (rd_real),
        .rd_imag      (rd_imag),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .src_real     (src_real),
        .src_imag     (src_imag),
        .src_error    (src_error),
        .src_fftpts   (src_fftpts)
    );

    // RAM model: real = address, imag = 100 + address; garbage when not read.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_real <= 32'(rd_addr);
            rd_imag <= 32'(rd_addr) + 32'd100;
        end else begin
            rd_real <= 32'hdead_beef;
            rd_imag <= 32'hbad0_f00d;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic        sop;
        logic        eop;
    } exp_t;
    exp_t sb[$];

    // Ready generator: 0 = always 1, 1 = pattern 1,0,0,1,0,1..., 2 = random.
    int   ready_mode = 0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    initial begin
        int p = 0;
        src_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin src_ready = pat[p]; p = (p + 1) % 6; end
                2: src_ready = 1'($urandom_range(0, 1));
                default: begin src_ready = 1'b1; p = 0; end
            endcase
        end
    end

    // Monitor: scoreboard, stall stability, read credit, event timestamps.
    int          outst = 0, rd_cnt = 0, beats = 0, done_cnt = 0;
    int          first_rd_cyc = -1, first_valid_cyc = -1, eop_cyc = -1, done_cyc = -1;
    logic        stall_prev = 1'b0;
    logic [65:0] prev_out;
    logic [4:0]  exp_pts;
    logic        exp_inv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            outst      = 0;
            stall_prev = 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check("rd_credit", 128'(outst + 1 <= 2), 128'd1);
            end
            if (src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall_prev)
                check("stall_hold", {src_valid, src_real, src_imag, src_sop, src_eop},
                      {1'b1, prev_out});
            if (src_valid && src_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("beat", {src_real, src_imag, src_sop, src_eop},
                          {e.re, e.im, e.sop, e.eop});
                    check("fftpts", 128'(src_fftpts), 128'(exp_pts));
                end
                beats++;
                if (src_eop) eop_cyc = cyc;
            end
            outst      = outst + int'(rd_en) - int'(src_valid && src_ready);
            stall_prev = src_valid && !src_ready;
            prev_out   = {src_real, src_imag, src_sop, src_eop};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_expect(input int pts, input int base, input int stride,
                               input logic inv);
        for (int k = 0; k < pts; k++) begin
            exp_t e;
            logic [9:0] a;
            a     = 10'(base + k * stride);
            e.re  = inv ? 32'(a) + 32'd100 : 32'(a);
            e.im  = inv ? 32'(a) : 32'(a) + 32'd100;
            e.sop = (k == 0);
            e.eop = (k == pts - 1);
            sb.push_back(e);
        end
    endtask

    // Runs one legal frame; glitch > 0 pulses a bogus start that many cycles in.
    task automatic run_frame(input int pts, input int base, input int stride, input logic inv,
                             input logic chk_lat, input int glitch);
        int t0, d0;
        beats = 0; first_rd_cyc = -1; first_valid_cyc = -1; eop_cyc = -1; done_cyc = -1;
        d0 = done_cnt;
        exp_pts = 5'(pts);
        @(posedge clk); #1;
        start = 1'b1; start_pts = 5'(pts); start_base = 10'(base);
        start_stride = 10'(stride); start_inverse = inv;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        push_expect(pts, base, stride, inv);
        check("busy_run", 128'(busy), 128'd1);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != d0) break;
            if (glitch != 0 && i == glitch) begin
                start = 1'b1; start_pts = 5'd4; start_base = 10'd500; start_stride = 10'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_seen", 128'(done_cnt - d0), 128'd1);
        check("beat_count", 128'(beats), 128'(pts));
        check("sb_empty", 128'(sb.size()), 128'd0);
        check("busy_after", 128'(busy), 128'd0);
        if (chk_lat) begin
            check("lat_first_rd", 128'(first_rd_cyc - t0), 128'd0);
            check("lat_first_valid", 128'(first_valid_cyc - t0), 128'd1);
            check("lat_eop", 128'(eop_cyc - t0), 128'(pts));
            check("lat_done", 128'(done_cyc - t0), 128'(pts + 1));
        end
    endtask

    task automatic illegal_start(input int pts);
        int rc0;
        rc0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b1; start_pts = 5'(pts); start_base = 10'd0; start_stride = 10'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_err_pulse", 128'(cfg_err), 128'd1);
        check("cfg_err_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        check("cfg_err_clear", 128'(cfg_err), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("cfg_err_no_rd", 128'(rd_cnt - rc0), 128'd0);
        check("cfg_err_idle", 128'(busy), 128'd0);
    endtask

    typedef struct {
        int   pts;
        int   base;
        int   stride;
        int   mode;
        logic legal;
        logic chk_lat;
    } vec_t;
    vec_t vecs[11];

    initial begin
        vecs[0]  = '{8, 0, 1, 0, 1'b1, 1'b1};
        vecs[1]  = '{16, 1020, 4, 0, 1'b1, 1'b1};
        vecs[2]  = '{4, 10, 3, 1, 1'b1, 1'b0};
        vecs[3]  = '{2, 1023, 1023, 2, 1'b1, 1'b0};
        vecs[4]  = '{12, 0, 1, 0, 1'b0, 1'b0};
        vecs[5]  = '{0, 0, 1, 0, 1'b0, 1'b0};
        vecs[6]  = '{1, 0, 1, 0, 1'b0, 1'b0};
        vecs[7]  = '{3, 0, 1, 0, 1'b0, 1'b0};
        vecs[8]  = '{17, 0, 1, 0, 1'b0, 1'b0};
        vecs[9]  = '{16, 5, 7, 2, 1'b1, 1'b0};
        vecs[10] = '{2, 40, 0, 0, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; start_pts = '0; start_base = '0; start_stride = '0;
        start_inverse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, cfg_err, rd_en, src_valid, src_sop, src_eop}, 128'd0);
        check("rst_data", {rd_addr, src_real, src_imag, src_fftpts, src_error}, 128'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            ready_mode = vecs[i].mode;
            if (vecs[i].legal)
                run_frame(vecs[i].pts, vecs[i].base, vecs[i].stride, 1'b0, vecs[i].chk_lat, 0);
            else
                illegal_start(vecs[i].pts);
        end

        // Start during RUN is ignored; the frame completes unaltered.
        ready_mode = 1;
        run_frame(8, 100, 5, 1'b0, 1'b0, 3);
        ready_mode = 0;

        // Reset in the middle of an N=16 frame.
        @(posedge clk); #1;
        start = 1'b1; start_pts = 5'd16; start_base = 10'd0; start_stride = 10'd1;
        exp_pts = 5'd16;
        @(posedge clk); #1;
        start = 1'b0;
        push_expect(16, 0, 1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {src_valid, busy, rd_en}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        run_frame(2, 7, 1, 1'b0, 1'b1, 0);

`ifdef FFT_FEEDER_INV_EN
        run_frame(4, 5, 1, 1'b1, 1'b0, 0);
        exp_inv = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
